// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared state encoding and halt word for the mips32 fetch controller
package mips32_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Opcode 6'b111111 with zero fields: never emitted by the toolchain, marks end of program.
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFC00_0000;

    function automatic logic is_busy_state(input logic [2:0] s);
        return (s == ST_FETCH) || (s == ST_ISSUE) || (s == ST_GAP);
    endfunction

endpackage

// File: rtl/mips32_fetch_ctrl_if.sv
// rtl/mips32_fetch_ctrl_if.sv - bundle of control, ROM and core-side signals around the fetch controller
interface mips32_fetch_ctrl_if #(
    parameter int AW = 4
);
    logic          start;
    logic          abort;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic [31:0]   instruction;
    logic          instr_valid;
    logic          busy;
    logic          done;
    logic [AW:0]   retired;

    // master: the host/ROM side that drives commands and memory data
    modport master (
        output start, abort, imem_data,
        input  imem_addr, instruction, instr_valid, busy, done, retired
    );

    modport slave (
        input  start, abort, imem_data,
        output imem_addr, instruction, instr_valid, busy, done, retired
    );
endinterface

// File: rtl/mips32_fetch_ctrl.sv
// rtl/mips32_fetch_ctrl.sv - steps a mips32 core through a ROM program, one word per issue slot
module mips32_fetch_ctrl
    import mips32_pkg::*;
#(
    parameter int          NUM_INSTR = 10,
    parameter int          AW        = 4,
    parameter int          ISSUE_GAP = 2,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_data,
    output logic [31:0]   instruction,
    output logic          instr_valid,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   retired
);

    localparam logic [AW:0] LAST_COUNT = (AW+1)'(NUM_INSTR);
    localparam logic [3:0]  GAP_LOAD   = (ISSUE_GAP > 0) ? 4'(ISSUE_GAP - 1) : 4'd0;

    logic [2:0]    state_q,   state_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic [31:0]   instr_q,   instr_d;
    logic          valid_q,   valid_d;
    logic [AW:0]   retired_q, retired_d;
    logic [3:0]    gap_q,     gap_d;
    logic [AW:0]   retired_inc;

    assign retired_inc = retired_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        valid_d   = 1'b0;
        retired_d = retired_q;
        gap_d     = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    addr_d    = '0;
                    retired_d = '0;
                end
            end
            ST_FETCH: begin
                state_d = abort ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (abort || (imem_data == HALT_WORD)) begin
                    state_d = ST_DONE;
                end else begin
                    instr_d = imem_data;
                    valid_d = 1'b1;
                    if (retired_q < LAST_COUNT) begin
                        retired_d = retired_inc;
                    end
                    // The last word leaves the address parked on NUM_INSTR-1 rather than wrapping.
                    if (retired_inc >= LAST_COUNT) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        gap_d   = GAP_LOAD;
                        state_d = (ISSUE_GAP == 0) ? ST_FETCH : ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_DONE;
                end else if (gap_q == 4'd0) begin
                    state_d = ST_FETCH;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            ST_DONE: begin
                // Holding start high parks here so a stuck start cannot trigger a rerun.
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            retired_q <= '0;
            gap_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            retired_q <= retired_d;
            gap_q     <= gap_d;
        end
    end

    assign imem_addr   = addr_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign retired     = retired_q;
    assign busy        = is_busy_state(state_q);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_mips32_fetch_ctrl.sv
// tb/tb_mips32_fetch_ctrl.sv - randomized self-checking bench for mips32_fetch_ctrl
module tb_mips32_fetch_ctrl;

    localparam int          NUM   = 10;
    localparam int          AW    = 4;
    localparam int          GAP_A = 2;
    localparam int          GAP_B = 0;
    localparam logic [31:0] HALT  = 32'hFC00_0000;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mips32_fetch_ctrl_if #(.AW(AW)) bus_a ();
    mips32_fetch_ctrl_if #(.AW(AW)) bus_b ();

    mips32_fetch_ctrl #(.NUM_INSTR(NUM), .AW(AW), .ISSUE_GAP(GAP_A)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(bus_a.start), .abort(bus_a.abort),
        .imem_addr(bus_a.imem_addr), .imem_data(bus_a.imem_data),
        .instruction(bus_a.instruction), .instr_valid(bus_a.instr_valid),
        .busy(bus_a.busy), .done(bus_a.done), .retired(bus_a.retired)
    );

    mips32_fetch_ctrl #(.NUM_INSTR(NUM), .AW(AW), .ISSUE_GAP(GAP_B)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(bus_b.start), .abort(bus_b.abort),
        .imem_addr(bus_b.imem_addr), .imem_data(bus_b.imem_data),
        .instruction(bus_b.instruction), .instr_valid(bus_b.instr_valid),
        .busy(bus_b.busy), .done(bus_b.done), .retired(bus_b.retired)
    );

    logic [31:0] rom [16];
    always @(posedge clk) begin
        bus_a.imem_data <= rom[bus_a.imem_addr];
        bus_b.imem_data <= rom[bus_b.imem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          q_c_a[$];
    int          q_c_b[$];
    logic [31:0] q_w_a[$];
    logic [31:0] q_w_b[$];
    always @(negedge clk) begin
        if (bus_a.instr_valid === 1'b1) begin
            q_c_a.push_back(cyc);
            q_w_a.push_back(bus_a.instruction);
        end
        if (bus_b.instr_valid === 1'b1) begin
            q_c_b.push_back(cyc);
            q_w_b.push_back(bus_b.instruction);
        end
    end

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_a, last_b;

    function automatic int n_issued(input bit sel);
        return sel ? q_w_b.size() : q_w_a.size();
    endfunction

    task automatic fill_rom();
        for (int i = 0; i < 16; i++) begin
            rom[i] = ($urandom & 32'hFFFF_FF00) | 32'(i);
            if (rom[i] == HALT) rom[i] = rom[i] ^ 32'h0000_0100;
        end
    endtask

    // Reference: words issue in address order until the halt word, the abort point or NUM_INSTR.
    task automatic build_expected(input int abort_after);
        exp_q.delete();
        for (int i = 0; i < NUM; i++) begin
            if (rom[i] == HALT) break;
            if (abort_after >= 0 && i >= abort_after) break;
            exp_q.push_back(rom[i]);
        end
    endtask

    task automatic clear_mon(input bit sel);
        if (sel) begin q_c_b.delete(); q_w_b.delete(); end
        else     begin q_c_a.delete(); q_w_a.delete(); end
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) bus_b.start = 1'b1; else bus_a.start = 1'b1;
        @(negedge clk);
        if (sel) bus_b.start = 1'b0; else bus_a.start = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((sel ? bus_b.done : bus_a.done) === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s done_timeout got=0 exp=1 within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_issues(input bit sel, input int k, input string name);
        int i = 0;
        while (n_issued(sel) < k && i < 200) begin
            @(negedge clk); #1;
            i++;
        end
        checks++;
        if (n_issued(sel) < k) begin
            failures++;
            $display("FAIL %s issue_timeout got=%0d exp>=%0d", name, n_issued(sel), k);
        end
    endtask

    task automatic verify_run(input bit sel, input int gap, input string name);
        int          n;
        bit          bad;
        logic [31:0] exp_instr;
        logic [31:0] got_instr;
        logic [AW:0] got_ret;
        n = n_issued(sel);
        checks++;
        if (n != exp_q.size()) begin
            failures++;
            $display("FAIL %s issue_count got=%0d exp=%0d", name, n, exp_q.size());
        end
        bad = 1'b0;
        for (int i = 0; i < n && i < exp_q.size(); i++)
            if ((sel ? q_w_b[i] : q_w_a[i]) !== exp_q[i]) bad = 1'b1;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s issue_words got_first=%h exp_first=%h",
                     name, (n > 0) ? (sel ? q_w_b[0] : q_w_a[0]) : 32'h0, rom[0]);
        end
        bad = 1'b0;
        for (int i = 1; i < n; i++)
            if ((sel ? (q_c_b[i] - q_c_b[i-1]) : (q_c_a[i] - q_c_a[i-1])) != 2 + gap) bad = 1'b1;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s issue_spacing got_irregular exp=%0d cycles", name, 2 + gap);
        end
        got_ret = sel ? bus_b.retired : bus_a.retired;
        checks++;
        if (got_ret !== (AW+1)'(exp_q.size())) begin
            failures++;
            $display("FAIL %s retired got=%0d exp=%0d", name, got_ret, exp_q.size());
        end
        exp_instr = (exp_q.size() > 0) ? exp_q[exp_q.size()-1] : (sel ? last_b : last_a);
        got_instr = sel ? bus_b.instruction : bus_a.instruction;
        checks++;
        if (got_instr !== exp_instr) begin
            failures++;
            $display("FAIL %s instruction got=%h exp=%h", name, got_instr, exp_instr);
        end
        if (sel) last_b = exp_instr; else last_a = exp_instr;
        checks++;
        if ((sel ? bus_b.busy : bus_a.busy) !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_in_done got=1 exp=0", name);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus_a.start = 1'b0; bus_a.abort = 1'b0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0;
        last_a = 32'h0; last_b = 32'h0;
        fill_rom();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus_a.imem_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus_a.imem_addr); end
        checks++;
        if (bus_a.instruction !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus_a.instruction); end
        checks++;
        if ({bus_a.instr_valid, bus_a.busy, bus_a.done} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {bus_a.instr_valid, bus_a.busy, bus_a.done});
        end
        checks++;
        if (bus_a.retired !== '0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", bus_a.retired); end
        checks++;
        if ({bus_b.imem_addr, bus_b.instruction, bus_b.instr_valid, bus_b.busy, bus_b.done, bus_b.retired} !== '0) begin
            failures++; $display("FAIL reset_dut_b got=nonzero exp=all_zero");
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_run();
        fill_rom();
        build_expected(-1);
        clear_mon(0);
        pulse_start(0);
        wait_done(0, 200, "full_run");
        verify_run(0, GAP_A, "full_run");
        checks++;
        if (bus_a.imem_addr !== AW'(NUM - 1)) begin
            failures++; $display("FAIL full_run max_addr got=%0d exp=%0d", bus_a.imem_addr, NUM - 1);
        end
        @(negedge clk); #1;
        checks++;
        if ({bus_a.done, bus_a.busy} !== 2'b00) begin
            failures++; $display("FAIL full_run back_to_idle got=%b exp=00", {bus_a.done, bus_a.busy});
        end
    endtask

    task automatic test_early_halt();
        fill_rom();
        rom[3] = HALT;
        build_expected(-1);
        clear_mon(0);
        pulse_start(0);
        wait_done(0, 200, "halt_at_3");
        verify_run(0, GAP_A, "halt_at_3");
        checks++;
        if (bus_a.instruction !== rom[2]) begin
            failures++; $display("FAIL halt_at_3 instruction got=%h exp=%h", bus_a.instruction, rom[2]);
        end
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            fill_rom();
            rom[$urandom_range(0, NUM - 1)] = HALT;
            build_expected(-1);
            clear_mon(0);
            pulse_start(0);
            wait_done(0, 200, "halt_random");
            verify_run(0, GAP_A, "halt_random");
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        fill_rom();
        build_expected(5);
        clear_mon(0);
        pulse_start(0);
        wait_issues(0, 5, "abort_gap");
        bus_a.abort = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (bus_a.done !== 1'b1) begin failures++; $display("FAIL abort_gap done_next got=%b exp=1", bus_a.done); end
        verify_run(0, GAP_A, "abort_gap");
        repeat (6) @(negedge clk);
        #1;
        bus_a.abort = 1'b0;
        checks++;
        if (n_issued(0) != 5 || bus_a.busy !== 1'b0) begin
            failures++; $display("FAIL abort_gap after_abort got=%0d issues busy=%b exp=5 issues busy=0", n_issued(0), bus_a.busy);
        end
        for (int r = 0; r < 4; r++) begin
            int k, d;
            k = $urandom_range(1, NUM - 1);
            d = $urandom_range(0, GAP_A + 1);
            fill_rom();
            build_expected(k);
            clear_mon(0);
            pulse_start(0);
            wait_issues(0, k, "abort_random");
            repeat (d) begin @(negedge clk); #1; end
            bus_a.abort = 1'b1;
            @(negedge clk); #1;
            bus_a.abort = 1'b0;
            checks++;
            if (bus_a.done !== 1'b1) begin
                failures++; $display("FAIL abort_random done_next got=%b exp=1 k=%0d d=%0d", bus_a.done, k, d);
            end
            verify_run(0, GAP_A, "abort_random");
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_run();
        fill_rom();
        clear_mon(0);
        pulse_start(0);
        wait_issues(0, 5, "reset_mid");
        repeat (GAP_A + 1) begin @(negedge clk); #1; end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus_a.imem_addr, bus_a.instruction, bus_a.instr_valid, bus_a.busy, bus_a.done, bus_a.retired} !== '0) begin
            failures++; $display("FAIL reset_mid async_clear got=addr%0d instr%h busy%b exp=all_zero",
                                 bus_a.imem_addr, bus_a.instruction, bus_a.busy);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        last_a = 32'h0;
        checks++;
        if (n_issued(0) != 5) begin failures++; $display("FAIL reset_mid partial_issue got=%0d exp=5", n_issued(0)); end
        build_expected(-1);
        clear_mon(0);
        pulse_start(0);
        wait_done(0, 200, "reset_restart");
        checks++;
        if (n_issued(0) == 0 || q_w_a[0] !== rom[0]) begin
            failures++; $display("FAIL reset_restart first_word got=%h exp=%h", (n_issued(0) > 0) ? q_w_a[0] : 32'h0, rom[0]);
        end
        verify_run(0, GAP_A, "reset_restart");
        @(negedge clk);
    endtask

    task automatic test_gap0();
        fill_rom();
        build_expected(-1);
        clear_mon(1);
        @(negedge clk);
        bus_b.start = 1'b1;
        wait_done(1, 200, "gap0");
        verify_run(1, GAP_B, "gap0");
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (bus_b.done !== 1'b1 || n_issued(1) != NUM) begin
            failures++; $display("FAIL gap0 hold_start got=done%b issues%0d exp=done1 issues%0d", bus_b.done, n_issued(1), NUM);
        end
        bus_b.start = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus_b.done !== 1'b0) begin failures++; $display("FAIL gap0 release got=%b exp=0", bus_b.done); end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            fill_rom();
            if (r == 1) rom[$urandom_range(0, NUM - 1)] = HALT;
            build_expected(-1);
            clear_mon(1);
            pulse_start(1);
            wait_done(1, 200, "back_to_back");
            verify_run(1, GAP_B, "back_to_back");
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_run();
        test_early_halt();
        test_abort();
        test_reset_mid_run();
        test_gap0();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
